// File: rtl/operand_skid_reg_pkg.sv
// Shared types and defaults for the operand skid register: default widths,
// the occupancy state encoding and the occupancy transition function.
package operand_skid_reg_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_TAG_W = 4;

   // Encoding is {skid_v, main_v}; 2'b10 can never be reached.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } skid_state_e;

   function automatic skid_state_e skid_next(input skid_state_e s,
                                             input logic acc,
                                             input logic pop,
                                             input logic flush);
      skid_state_e n;
      n = s;
      if (flush) begin
         n = ST_EMPTY;
      end else begin
         unique case (s)
            ST_EMPTY: n = acc ? ST_ONE : ST_EMPTY;
            ST_ONE: begin
               if (acc && !pop)      n = ST_FULL;
               else if (!acc && pop) n = ST_EMPTY;
               else                  n = ST_ONE;
            end
            ST_FULL:  n = pop ? ST_ONE : ST_FULL;
            default:  n = ST_EMPTY;
         endcase
      end
      return n;
   endfunction

endpackage

// File: rtl/operand_skid_reg_if.sv
// Valid/ready handshake bundle between the operand mux, the skid register
// and the execute stage.
interface operand_skid_reg_if
   import operand_skid_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int TAG_W = DEF_TAG_W
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;

   // Skid register side.
   modport slave (
      input  in_valid, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );

   // Producer/consumer side wrapped around the skid register.
   modport master (
      output in_valid, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

endinterface

// File: rtl/operand_skid_reg_slot.sv
// One storage slot: a data register with its valid flag. Data changes only
// on load; clear wins over load for the valid flag.
module operand_skid_reg_slot #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o,
   output logic         v_o
);

   logic [W-1:0] data_q, data_d;
   logic         v_q, v_d;

   always_comb begin
      data_d = data_q;
      v_d    = v_q;
      if (load_i) begin
         data_d = d_i;
         v_d    = 1'b1;
      end
      if (clear_i) begin
         v_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         v_q    <= 1'b0;
      end else begin
         data_q <= data_d;
         v_q    <= v_d;
      end
   end

   assign q_o = data_q;
   assign v_o = v_q;

endmodule

// File: rtl/operand_skid_reg.sv
// Two-entry skid register holding the selected ALU operand word and its
// destination tag for the execute stage, with synchronous squash.
module operand_skid_reg
   import operand_skid_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int TAG_W = DEF_TAG_W
) (
   input logic                clk,
   input logic                rst_n,
   input logic                flush,
   operand_skid_reg_if.slave  bus
);

   localparam int EW = WIDTH + TAG_W;

   skid_state_e   state_q, state_d;
   logic          in_ready_q;
   logic          accept, pop;
   logic          main_load, main_clr, skid_load, skid_clr;
   logic [EW-1:0] in_entry, main_din, main_q, skid_q;
   logic          main_v, skid_v;

   assign in_entry = {bus.in_tag, bus.in_data};
   assign accept   = bus.in_valid & in_ready_q;
   assign pop      = main_v & bus.out_ready;
   assign state_d  = skid_next(state_q, accept, pop, flush);

   // The skid slot is only occupied when full, so it always refills main first.
   assign main_din = skid_v ? skid_q : in_entry;

   always_comb begin
      main_load = 1'b0;
      skid_load = 1'b0;
      main_clr  = flush;
      skid_clr  = flush;
      if (!flush) begin
         unique case (state_q)
            ST_EMPTY: main_load = accept;
            ST_ONE: begin
               main_load = accept & pop;
               skid_load = accept & ~pop;
               main_clr  = ~accept & pop;
            end
            ST_FULL: begin
               main_load = pop;
               skid_clr  = pop;
            end
            default: begin
               main_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
   end

   // in_ready is a flop computed from the next state, so out_ready never
   // reaches it combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_FULL);
      end
   end

   operand_skid_reg_slot #(.W(EW)) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (main_load),
      .clear_i (main_clr),
      .d_i     (main_din),
      .q_o     (main_q),
      .v_o     (main_v)
   );

   operand_skid_reg_slot #(.W(EW)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (skid_load),
      .clear_i (skid_clr),
      .d_i     (in_entry),
      .q_o     (skid_q),
      .v_o     (skid_v)
   );

   assign bus.in_ready               = in_ready_q;
   assign bus.out_valid              = main_v;
   assign {bus.out_tag, bus.out_data} = main_q;

endmodule
